mdr_unit: RTL and testbench

- Memory Data Register stage that sits directly beside the 32-to-1 bus multiplexer.
- Consumes the bus value (BusMuxOut) and produces MDRMuxIn, which feeds the multiplexer's MDR input (select code 5'b1_0110).
- Owns the memory-side read/write request/acknowledge handshake, so the control unit issues one-cycle commands and waits for done.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/mdr_wait_timer.sv | 38 +++
 rtl/mdr_unit.sv | 131 +++++++++++++
 tb/tb_mdr_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: bus width, MDR handshake states and
// bus-multiplexer select codes used by the MDR, the bus mux and the encoder.
package cpu_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mdr_state_e;

  // Bus multiplexer select code that routes MDRMuxIn onto the bus.
  localparam logic [4:0] SEL_MDR = 5'b1_0110;

endpackage

// File: rtl/mdr_wait_timer.sv
// Saturating wait-cycle counter for the MDR memory handshake; flags when the
// count has reached TIMEOUT_CYCLES. Only instantiated when MDR_TIMEOUT_EN is set.
module mdr_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clock,
  input  logic clear,
  input  logic start_i,
  input  logic wait_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Restart on every accepted command; hold at LIMIT instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (wait_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mdr_unit.sv
// Memory Data Register stage beside the bus mux, owning the memory read/write
// request/acknowledge handshake. Define MDR_TIMEOUT_EN to enable the wait timeout.
module mdr_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH          = cpu_pkg::WIDTH,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] BusMuxOut,
  input  logic             MDRin,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             mem_ack,
  output logic             mem_rd_req,
  output logic             mem_wr_req,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] MDRMuxIn,
  output logic             busy,
  output logic             done,
  output logic             err
);

  mdr_state_e       state_q, state_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic             done_q, done_d;
  logic             abort;

  assign busy = (state_q != IDLE);

  // Command priority in IDLE is read > write > bus load; everything but
  // mem_ack and abort is ignored while a memory cycle is outstanding.
  always_comb begin
    state_d = state_q;
    mdr_d   = mdr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read) begin
          state_d = RD_WAIT;
        end else if (mem_write) begin
          state_d = WR_WAIT;
        end else if (MDRin) begin
          mdr_d = BusMuxOut;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          mdr_d   = Mdatain;
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_ack || abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      mdr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
    end
  end

`ifdef MDR_TIMEOUT_EN
  logic start;
  logic timeout;
  logic err_q, err_d;

  assign start = (state_q == IDLE) && (mem_read || mem_write);
  assign abort = timeout && !mem_ack;

  mdr_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wait_timer (
    .clock    (clock),
    .clear    (clear),
    .start_i  (start),
    .wait_i   (busy && !mem_ack),
    .timeout_o(timeout)
  );

  // err is sticky from an abort until the next accepted memory command.
  always_comb begin
    err_d = err_q;
    if (start) begin
      err_d = 1'b0;
    end else if (busy && abort) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  assign mem_rd_req = (state_q == RD_WAIT);
  assign mem_wr_req = (state_q == WR_WAIT);
  assign mem_wdata  = mdr_q;
  assign MDRMuxIn   = mdr_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mdr_unit.sv
// Self-checking bench for mdr_unit: directed handshake scenarios plus random
// traffic compared every cycle against a transaction-level model.
module tb_mdr_unit;

  localparam int TB_TIMEOUT = 4;

  logic        clock;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MDRin;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] Mdatain;
  logic        mem_ack;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_wdata;
  logic [31:0] MDRMuxIn;
  logic        busy;
  logic        done;
  logic        err;

  int vectorCount = 0;
  int errCount    = 0;
  bit checkEn     = 1'b0;

  logic [31:0] expMdr   = '0;
  logic        expRdReq = 1'b0;
  logic        expWrReq = 1'b0;
  logic        expDone  = 1'b0;
  logic        expErr   = 1'b0;
  int          waitCnt  = 0;

  mdr_unit #(
    .WIDTH         (32),
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .CNT_W         (8)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .BusMuxOut (BusMuxOut),
    .MDRin     (MDRin),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .Mdatain   (Mdatain),
    .mem_ack   (mem_ack),
    .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req),
    .mem_wdata (mem_wdata),
    .MDRMuxIn  (MDRMuxIn),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge consume them, return just after it.
  task automatic applyStimulus(input logic clr, input logic rd, input logic wr, input logic ld,
                               input logic ack, input logic [31:0] bus, input logic [31:0] mdat);
    clear     = clr;
    mem_read  = rd;
    mem_write = wr;
    MDRin     = ld;
    mem_ack   = ack;
    BusMuxOut = bus;
    Mdatain   = mdat;
    @(posedge clock);
    #1;
  endtask

  // Transaction-level model: one outstanding memory request at most.
  always @(posedge clock) begin : model
    logic [31:0] m;
    logic rq, wq, d, e;
    int c;
    m = expMdr; rq = expRdReq; wq = expWrReq; d = 1'b0; e = expErr; c = waitCnt;
    if (clear) begin
      m = '0; rq = 1'b0; wq = 1'b0; e = 1'b0; c = 0;
    end else if (!rq && !wq) begin
      if (mem_read) begin
        rq = 1'b1; c = 0; e = 1'b0;
      end else if (mem_write) begin
        wq = 1'b1; c = 0; e = 1'b0;
      end else if (MDRin) begin
        m = BusMuxOut;
      end
    end else if (mem_ack) begin
      if (rq) m = Mdatain;
      rq = 1'b0; wq = 1'b0; d = 1'b1;
`ifdef MDR_TIMEOUT_EN
    end else if (c == TB_TIMEOUT) begin
      rq = 1'b0; wq = 1'b0; d = 1'b1; e = 1'b1;
`endif
    end else if (c < TB_TIMEOUT) begin
      c = c + 1;
    end
    expMdr   <= m;
    expRdReq <= rq;
    expWrReq <= wq;
    expDone  <= d;
    expErr   <= e;
    waitCnt  <= c;
  end

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("MDRMuxIn", MDRMuxIn, expMdr);
      checkOutput("mem_wdata", mem_wdata, expMdr);
      checkOutput("mem_rd_req", {31'd0, mem_rd_req}, {31'd0, expRdReq});
      checkOutput("mem_wr_req", {31'd0, mem_wr_req}, {31'd0, expWrReq});
      checkOutput("busy", {31'd0, busy}, {31'd0, expRdReq | expWrReq});
      checkOutput("done", {31'd0, done}, {31'd0, expDone});
      checkOutput("err", {31'd0, err}, {31'd0, expErr});
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rdCycles;
    int n;
    clear = 1'b0; mem_read = 1'b0; mem_write = 1'b0; MDRin = 1'b0;
    mem_ack = 1'b0; BusMuxOut = '0; Mdatain = '0;

    // Reset held two cycles with every command active.
    applyStimulus(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkEn = 1'b1;
    checkOutput("reset_mdr", MDRMuxIn, 32'h0000_0000);
    checkOutput("reset_outs", {26'd0, mem_rd_req, mem_wr_req, busy, done, err, 1'b0}, 32'd0);

    // Bus load.
    applyStimulus(0, 0, 0, 1, 0, 32'hDEAD_BEEF, 32'h0);
    checkOutput("load_mdr", MDRMuxIn, 32'hDEAD_BEEF);
    checkOutput("load_busy_done", {30'd0, busy, done}, 32'd0);

    // Read with three wait states, ack on the fourth request cycle.
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h1234_5678);
    rdCycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_rd_req) rdCycles++;
      applyStimulus(0, 0, 0, 0, (i == 3), 32'h0, 32'h1234_5678);
    end
    checkOutput("read_req_cycles", rdCycles, 32'd4);
    checkOutput("read_mdr", MDRMuxIn, 32'h1234_5678);
    checkOutput("read_done", {31'd0, done}, 32'd1);
    checkOutput("read_req_drop", {30'd0, mem_rd_req, busy}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("read_done_single", {31'd0, done}, 32'd0);

    // Zero-wait write.
    applyStimulus(0, 0, 0, 1, 0, 32'hCAFE_F00D, 32'h0);
    applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0);
    checkOutput("write_req", {31'd0, mem_wr_req}, 32'd1);
    checkOutput("write_wdata", mem_wdata, 32'hCAFE_F00D);
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'h5555_5555);
    checkOutput("write_done", {31'd0, done}, 32'd1);
    checkOutput("write_req_drop", {31'd0, mem_wr_req}, 32'd0);
    checkOutput("write_mdr_kept", MDRMuxIn, 32'hCAFE_F00D);

    // Collisions: read wins; MDRin during busy is ignored.
    applyStimulus(0, 1, 1, 1, 0, 32'h0000_0001, 32'h0);
    checkOutput("collide_reqs", {30'd0, mem_rd_req, mem_wr_req}, 32'd2);
    checkOutput("collide_mdr", MDRMuxIn, 32'hCAFE_F00D);
    applyStimulus(0, 0, 0, 1, 0, 32'h0000_0001, 32'hA5A5_A5A5);
    checkOutput("busy_load_ignored", MDRMuxIn, 32'hCAFE_F00D);
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'hA5A5_A5A5);
    checkOutput("collide_read_mdr", MDRMuxIn, 32'hA5A5_A5A5);

    // Long wait with no ack.
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h0BAD_0BAD);
    n = 0;
    while (mem_rd_req && n < 20) begin
      n++;
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0BAD_0BAD);
    end
`ifdef MDR_TIMEOUT_EN
    checkOutput("timeout_req_cycles", n, TB_TIMEOUT + 1);
    checkOutput("timeout_done_err", {30'd0, done, err}, 32'd3);
    checkOutput("timeout_mdr_kept", MDRMuxIn, 32'hA5A5_A5A5);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("timeout_err_sticky", {30'd0, done, err}, 32'd1);
    applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0);
    checkOutput("timeout_err_cleared", {31'd0, err}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'h0);
`else
    checkOutput("nowait_limit_req", {31'd0, mem_rd_req}, 32'd1);
    checkOutput("nowait_limit_err", {31'd0, err}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'h0BAD_0BAD);
    checkOutput("late_ack_mdr", MDRMuxIn, 32'h0BAD_0BAD);
`endif

    // Clear in the middle of a read.
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h7777_7777);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h7777_7777);
    applyStimulus(1, 0, 0, 0, 1, 32'h0, 32'h7777_7777);
    checkOutput("clear_mid_read", {29'd0, mem_rd_req, busy, done}, 32'd0);
    checkOutput("clear_mdr", MDRMuxIn, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("clear_no_done", {31'd0, done}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 63) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0,
                    $urandom(), $urandom());
    end

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errCount);
    $finish;
  end

endmodule
